// File: rtl/sd_dac_pkg.sv
// -----------------------------------------------------------------------------
// sd_dac_pkg
//   Shared definitions for the sigma-delta DAC test path.
//   - dec_state_t : decimator state (SETTLE while discarding start-up windows,
//                   RUN once windows are being reported)
//   - SEG_BLANK   : all segments off (active-low) for one digit
//   - hex7()      : nibble -> active-low {g,f,e,d,c,b,a} glyph, 0-9 and A-F
//   - osr_is_legal(): oversampling ratio must be a power of two in 2..128
// -----------------------------------------------------------------------------
package sd_dac_pkg;

  typedef enum logic [0:0] {
    SETTLE = 1'b0,
    RUN    = 1'b1
  } dec_state_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  function automatic logic [6:0] hex7(input logic [3:0] nibble);
    logic [6:0] glyph;
    case (nibble)
      4'h0:    glyph = 7'h40;
      4'h1:    glyph = 7'h79;
      4'h2:    glyph = 7'h24;
      4'h3:    glyph = 7'h30;
      4'h4:    glyph = 7'h19;
      4'h5:    glyph = 7'h12;
      4'h6:    glyph = 7'h02;
      4'h7:    glyph = 7'h78;
      4'h8:    glyph = 7'h00;
      4'h9:    glyph = 7'h10;
      4'hA:    glyph = 7'h08;
      4'hB:    glyph = 7'h03;
      4'hC:    glyph = 7'h46;
      4'hD:    glyph = 7'h21;
      4'hE:    glyph = 7'h06;
      default: glyph = 7'h0E;  // F
    endcase
    return glyph;
  endfunction

  function automatic bit osr_is_legal(input int osr);
    return (osr >= 2) && (osr <= 128) && ((osr & (osr - 1)) == 0);
  endfunction

endpackage

// File: rtl/sevenseg_hex_dec.sv
// -----------------------------------------------------------------------------
// sevenseg_hex_dec
//   Combinational single-digit hex decoder for a 7-segment display.
//   Only present when SEVENSEG_EN is defined; the decimator is its sole user.
// Ports
//   nibble  in  4  value to display, 0..F
//   seg     out 7  active-low {g,f,e,d,c,b,a}
// -----------------------------------------------------------------------------
`ifdef SEVENSEG_EN
module sevenseg_hex_dec
  import sd_dac_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = hex7(nibble);

endmodule
`endif

// File: rtl/sd_bitstream_decimator.sv
// -----------------------------------------------------------------------------
// sd_bitstream_decimator
//   Integrate-and-dump decimator for the 1-bit sigma-delta stream from the MASH
//   DAC modulator. Counts ones over OSR enabled samples and reports the signed
//   average 2*ones - OSR once per window. The first SETTLE_WIN windows after
//   reset are computed but not reported, letting the modulator settle.
//
// Parameters
//   OSR         window length in sample_en cycles (power of two, 2..128)
//   SETTLE_WIN  windows discarded after reset (0 = report from the first one)
//
// Ports
//   clck        in   1   clock, rising edge
//   rst         in   1   synchronous active-low reset
//   bit_in      in   1   modulator bit (1 = +1, 0 = -1)
//   sample_en   in   1   one sample consumed per high cycle
//   dout        out  W   signed average, W = $clog2(OSR)+2, range -OSR..+OSR
//   ones_cnt    out  8   ones in the last reported window, 0..OSR
//   dout_valid  out  1   one-cycle strobe when dout/ones_cnt update
//   settled     out  1   high once the start-up windows are discarded
//   seg_out     out  14  {digit1, digit0} active-low hex of ones_cnt
//                        (only when SEVENSEG_EN is defined)
// -----------------------------------------------------------------------------
module sd_bitstream_decimator
  import sd_dac_pkg::*;
#(
  parameter int OSR        = 16,
  parameter int SETTLE_WIN = 1
) (
  input  logic                          clck,
  input  logic                          rst,
  input  logic                          bit_in,
  input  logic                          sample_en,
  output logic signed [$clog2(OSR)+1:0] dout,
  output logic [7:0]                    ones_cnt,
  output logic                          dout_valid,
  output logic                          settled
`ifdef SEVENSEG_EN
  ,
  output logic [13:0]                   seg_out
`endif
);

  localparam int CW  = $clog2(OSR);  // window counter width
  localparam int AW  = CW + 1;       // accumulator holds 0..OSR
  localparam int W   = CW + 2;       // signed output holds -OSR..+OSR
  localparam int SCW = (SETTLE_WIN > 1) ? $clog2(SETTLE_WIN) : 1;

  localparam logic [SCW-1:0] SETTLE_LAST = SCW'((SETTLE_WIN > 0) ? SETTLE_WIN - 1 : 0);
  localparam dec_state_t     RESET_STATE = (SETTLE_WIN == 0) ? RUN : SETTLE;

  if (!osr_is_legal(OSR)) begin : g_bad_osr
    $error("sd_bitstream_decimator: OSR=%0d must be a power of two in 2..128", OSR);
  end
  if (SETTLE_WIN < 0) begin : g_bad_settle
    $error("sd_bitstream_decimator: SETTLE_WIN=%0d must be >= 0", SETTLE_WIN);
  end

  logic [CW-1:0]  win_cnt;
  logic [AW-1:0]  acc;
  logic [SCW-1:0] settle_cnt;
  dec_state_t     state;

  logic           dump;
  logic [AW-1:0]  total;
  logic [W-1:0]   dout_next;
  logic [7:0]     ones_next;

  // The last sample of a window is folded into the total on the same cycle
  // the accumulator restarts, so every sample lands in exactly one window.
  assign dump      = sample_en && (win_cnt == CW'(OSR - 1));
  assign total     = acc + AW'(bit_in);
  assign dout_next = {total, 1'b0} - W'(OSR);
  assign ones_next = 8'(total);

  assign settled   = (state == RUN);

`ifdef SEVENSEG_EN
  logic [6:0] digit1_next;
  logic [6:0] digit0_next;

  sevenseg_hex_dec u_dec_hi (
    .nibble (ones_next[7:4]),
    .seg    (digit1_next)
  );

  sevenseg_hex_dec u_dec_lo (
    .nibble (ones_next[3:0]),
    .seg    (digit0_next)
  );
`endif

  // NOTE: all state here is updated with non-blocking assignments so every
  // register sees the pre-edge values of the others (acc, win_cnt and the
  // output registers all read the same 'total' on a dump edge).
  always_ff @(posedge clck) begin
    if (!rst) begin
      win_cnt    <= '0;
      acc        <= '0;
      settle_cnt <= '0;
      state      <= RESET_STATE;
      dout       <= '0;
      ones_cnt   <= '0;
      dout_valid <= 1'b0;
`ifdef SEVENSEG_EN
      seg_out    <= {SEG_BLANK, SEG_BLANK};
`endif
    end else begin
      dout_valid <= 1'b0;

      if (sample_en) begin
        win_cnt <= win_cnt + 1'b1;
        acc     <= dump ? '0 : total;
      end

      if (dump) begin
        case (state)
          SETTLE: begin
            settle_cnt <= settle_cnt + 1'b1;
            if (settle_cnt == SETTLE_LAST) begin
              state <= RUN;
            end
          end
          RUN: begin
            ones_cnt   <= ones_next;
            dout       <= signed'(dout_next);
            dout_valid <= 1'b1;
`ifdef SEVENSEG_EN
            seg_out    <= {digit1_next, digit0_next};
`endif
          end
          default: state <= RESET_STATE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sd_bitstream_decimator.sv
// -----------------------------------------------------------------------------
// tb_sd_bitstream_decimator
//   Scoreboard bench. The main process drives samples into a window model kept
//   as a plain list of bits; each completed, reportable window pushes its ones
//   count into exp_q. A monitor pops exp_q whenever dout_valid is seen.
//   A second instance (OSR=4, SETTLE_WIN=0) is checked directly at the end.
//   Build with +define+SEVENSEG_EN to also check seg_out.
// -----------------------------------------------------------------------------
module tb_sd_bitstream_decimator;

  localparam int OSR  = 16;
  localparam int SW   = 1;
  localparam int OSR2 = 4;

  logic        clck = 1'b0;
  logic        rst = 1'b0;
  logic        bit_in = 1'b0;
  logic        sample_en = 1'b0;
  logic signed [5:0] dout;
  logic [7:0]  ones_cnt;
  logic        dout_valid;
  logic        settled;

  logic        rst2 = 1'b0;
  logic        bit_in2 = 1'b0;
  logic        sample_en2 = 1'b0;
  logic signed [3:0] dout2;
  logic [7:0]  ones_cnt2;
  logic        dout_valid2;
  logic        settled2;

`ifdef SEVENSEG_EN
  logic [13:0] seg_out;
  logic [13:0] seg_out2;
`endif

  always #5 clck = ~clck;

  sd_bitstream_decimator #(.OSR(OSR), .SETTLE_WIN(SW)) dut (
    .clck       (clck),
    .rst        (rst),
    .bit_in     (bit_in),
    .sample_en  (sample_en),
    .dout       (dout),
    .ones_cnt   (ones_cnt),
    .dout_valid (dout_valid),
    .settled    (settled)
`ifdef SEVENSEG_EN
    ,
    .seg_out    (seg_out)
`endif
  );

  sd_bitstream_decimator #(.OSR(OSR2), .SETTLE_WIN(0)) dut2 (
    .clck       (clck),
    .rst        (rst2),
    .bit_in     (bit_in2),
    .sample_en  (sample_en2),
    .dout       (dout2),
    .ones_cnt   (ones_cnt2),
    .dout_valid (dout_valid2),
    .settled    (settled2)
`ifdef SEVENSEG_EN
    ,
    .seg_out    (seg_out2)
`endif
  );

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;

  int win_bits[$];
  int windows_done = 0;
  int exp_q[$];
  int valid_cyc[$];

  logic [6:0] glyph [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                             7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  always @(posedge clck) cyc <= cyc + 1;

  task automatic check(input string name, input logic signed [31:0] act,
                       input logic signed [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
               name, act, act, exp, exp, cyc);
    end
  endtask

  function automatic logic [13:0] seg_of(input int ones);
    logic [7:0] v;
    v = 8'(ones);
    return {glyph[v[7:4]], glyph[v[3:0]]};
  endfunction

  // Reference model: collect accepted bits; each full window is summed, and
  // reported only after the first SW windows since reset.
  task automatic model_sample(input int b);
    int ones;
    win_bits.push_back(b);
    if (win_bits.size() == OSR) begin
      ones = 0;
      foreach (win_bits[i]) ones += win_bits[i];
      windows_done++;
      if (windows_done > SW) exp_q.push_back(ones);
      win_bits.delete();
    end
  endtask

  task automatic drive(input int b, input int en);
    bit_in    = 1'(b);
    sample_en = 1'(en);
    if (en != 0 && rst) model_sample(b);
    @(posedge clck);
    #1;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      drive(0, 0);
      n++;
    end
    check("drain_pending", exp_q.size(), 0);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b0;
    repeat (n) begin
      bit_in    = 1'($urandom);
      sample_en = 1'($urandom);
      @(posedge clck);
      #1;
    end
    win_bits.delete();
    windows_done = 0;
    exp_q.delete();
    check("rst_dout", dout, 0);
    check("rst_ones_cnt", ones_cnt, 0);
    check("rst_dout_valid", dout_valid, 0);
    check("rst_settled", settled, 0);
`ifdef SEVENSEG_EN
    check("rst_seg_out", seg_out, 14'h3FFF);
`endif
    rst = 1'b1;
    sample_en = 1'b0;
  endtask

  task automatic drive2(input int b);
    bit_in2    = 1'(b);
    sample_en2 = 1'b1;
    @(posedge clck);
    #1;
  endtask

  // Monitor: every valid strobe must match the oldest expected window.
  initial begin
    int e;
    forever begin
      @(negedge clck);
      if (dout_valid === 1'b1) begin
        valid_cyc.push_back(cyc);
        if (exp_q.size() == 0) begin
          check("spurious_valid", dout_valid, 0);
        end else begin
          e = exp_q.pop_front();
          check("dout", $signed(dout), 2 * e - OSR);
          check("ones_cnt", ones_cnt, e);
`ifdef SEVENSEG_EN
          check("seg_out", seg_out, seg_of(e));
`endif
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    // 1: reset with random inputs
    do_reset(3);

    // 2: settle with all ones; settled rises after the 16th sample
    for (int i = 0; i < OSR - 1; i++) drive(1, 1);
    check("settled_before_first_dump", settled, 0);
    drive(1, 1);
    check("settled_after_first_dump", settled, 1);
    check("no_valid_during_settle", dout_valid, 0);
`ifdef SEVENSEG_EN
    check("seg_blank_after_settle", seg_out, 14'h3FFF);
`endif
    for (int i = 0; i < 2 * OSR; i++) drive(1, 1);
    drain();
    if (valid_cyc.size() >= 2)
      check("back_to_back_gap", valid_cyc[$] - valid_cyc[$-1], OSR);
    else
      check("back_to_back_count", valid_cyc.size(), 2);

    // 3: densities: 12 ones + 4 zeros, all zeros, alternating
    for (int w = 0; w < 2; w++)
      for (int i = 0; i < OSR; i++) drive((i < 12) ? 1 : 0, 1);
    for (int i = 0; i < OSR; i++) drive(0, 1);
    for (int i = 0; i < OSR; i++) drive((i % 2 == 0) ? 1 : 0, 1);
    drain();

    // 4: stall every other cycle with all ones
    for (int w = 0; w < 3; w++)
      for (int i = 0; i < OSR; i++) begin
        drive(1, 1);
        drive(1, 0);
      end
    drain();
    n = valid_cyc.size();
    if (n >= 2) check("stall_gap", valid_cyc[n-1] - valid_cyc[n-2], 2 * OSR);
    else        check("stall_count", n, 2);

    // Random bits with random enable gaps
    for (int i = 0; i < 300; i++) drive(int'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0) ? 1 : 0);
    for (int i = 0; i < OSR; i++) drive(int'($urandom_range(0, 1)), 1);
    drain();

    // 5: reset after 7 samples of window 3
    do_reset(2);
    for (int i = 0; i < 2 * OSR + 7; i++) drive(int'($urandom_range(0, 1)), 1);
    drain();
    do_reset(2);
    for (int i = 0; i < OSR - 1; i++) drive(int'($urandom_range(0, 1)), 1);
    check("settled_repeat_before", settled, 0);
    drive(int'($urandom_range(0, 1)), 1);
    check("settled_repeat_after", settled, 1);
    for (int i = 0; i < OSR; i++) drive(int'($urandom_range(0, 1)), 1);
    drain();

    // 6: OSR=4, SETTLE_WIN=0 instance
    sample_en = 1'b0;
    rst2 = 1'b0;
    repeat (2) @(posedge clck);
    #1;
    rst2 = 1'b1;
    check("dut2_settled_from_reset", settled2, 1);
    check("dut2_no_valid_after_reset", dout_valid2, 0);
    drive2(1);
    drive2(1);
    drive2(0);
    check("dut2_no_valid_mid_window", dout_valid2, 0);
    drive2(1);
    check("dut2_valid", dout_valid2, 1);
    check("dut2_dout", $signed(dout2), 2);
    check("dut2_ones_cnt", ones_cnt2, 3);
`ifdef SEVENSEG_EN
    check("dut2_seg_out", seg_out2, seg_of(3));
`endif
    drive2(0);
    check("dut2_valid_one_cycle", dout_valid2, 0);
    check("dut2_dout_holds", $signed(dout2), 2);
    drive2(0);
    drive2(0);
    drive2(0);
    check("dut2_zero_dout", $signed(dout2), -4);
    check("dut2_zero_ones", ones_cnt2, 0);
    repeat (4) drive2(1);
    check("dut2_full_dout", $signed(dout2), 4);
    check("dut2_full_ones", ones_cnt2, 4);
    sample_en2 = 1'b0;

    @(posedge clck);
    #1;
    $display("test done: total=%0d bad=%0d", checks, fails);
    $finish;
  end

endmodule
